// File: rtl/proximity_alarm_sequencer.sv
// Proximity alarm sequencer: qualifies near/far distance samples, runs the
// IDLE/ARMED/ALERT/HOLD state machine, gates a distance-modulated beep tone
// and serialises 16-bit signed audio samples into framed DAC bitstreams.
module proximity_alarm_sequencer #(
    parameter int          THRESH    = 100,
    parameter int          CONFIRM_N = 4,
    parameter int          HOLD_CYC  = 50000,
    parameter int          TONE_HALF = 25,
    parameter int          BEEP_ON   = 5000,
    parameter int          OFF_SCALE = 100,
    parameter logic [15:0] AMP       = 16'h3000,
    parameter int          FRAME_LEN = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] Distance,
    input  logic       Dist_Valid,
    input  logic       Enable,
    output logic       Alarm,
    output logic [1:0] State,
    output logic       Sound_Data,
    output logic       Sound_Trig
);
    localparam int CW = $clog2(CONFIRM_N + 1);
    localparam int FW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] CONF = CW'(CONFIRM_N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_ALERT = 2'b10,
        S_HOLD  = 2'b11
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_near_cnt, r_far_cnt, w_near_nxt, w_far_nxt;
    logic               w_clr_cnt;
    logic               w_near, w_far, w_zero, w_enter_alert;
    logic [31:0]        r_hold_cnt;
    logic [7:0]         r_latched;
    logic               r_beep_on;
    logic [31:0]        r_gate_cnt, r_off_len, w_off_len;
    logic [31:0]        r_tone_cnt;
    logic               r_tone;
    logic [FW-1:0]      r_frame_cnt;
    logic signed [15:0] r_shift, w_sample;
    logic               r_alarm, r_sdata, r_strig;

    assign w_near = Dist_Valid && (Distance != 8'd0) && ({24'd0, Distance} < 32'(THRESH));
    assign w_far  = Dist_Valid && (Distance != 8'd0) && ({24'd0, Distance} >= 32'(THRESH));
    assign w_zero = Dist_Valid && (Distance == 8'd0);

    // Confirmation counters after the current strobe; the FSM decides on these
    // so a transition lands on the edge that samples the qualifying strobe.
    always_comb begin
        w_near_nxt = r_near_cnt;
        w_far_nxt  = r_far_cnt;
        if (w_near) begin
            w_near_nxt = (r_near_cnt == CONF) ? CONF : r_near_cnt + 1'b1;
            w_far_nxt  = '0;
        end else if (w_far) begin
            w_far_nxt  = (r_far_cnt == CONF) ? CONF : r_far_cnt + 1'b1;
            w_near_nxt = '0;
        end else if (w_zero) begin
            w_near_nxt = '0;
            w_far_nxt  = '0;
        end
    end

    // Next-state logic; Enable low overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_cnt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clr_cnt = 1'b1;
                if (Enable) w_state_nxt = S_ARMED;
            end
            S_ARMED: if (w_near_nxt == CONF) w_state_nxt = S_ALERT;
            S_ALERT: if (w_far_nxt == CONF) w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (w_near) begin
                    w_state_nxt = S_ALERT;
                end else if (r_hold_cnt == 32'(HOLD_CYC - 1)) begin
                    w_state_nxt = S_ARMED;
                    w_clr_cnt   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (!Enable) begin
            w_state_nxt = S_IDLE;
            w_clr_cnt   = 1'b1;
        end
    end

    assign w_enter_alert = (w_state_nxt == S_ALERT) && (r_state != S_ALERT);

    // State register, confirmation counters, hold timer and alarm output.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_near_cnt <= '0;
            r_far_cnt  <= '0;
            r_hold_cnt <= '0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_near_cnt <= w_clr_cnt ? '0 : w_near_nxt;
            r_far_cnt  <= w_clr_cnt ? '0 : w_far_nxt;
            r_hold_cnt <= (r_state == S_HOLD && w_state_nxt == S_HOLD) ? r_hold_cnt + 32'd1 : 32'd0;
            r_alarm    <= (w_state_nxt == S_ALERT);
        end
    end

    // Gap length is fixed when an off phase starts, so a distance latched
    // during the on phase only affects the following gap.
    assign w_off_len = ((r_latched == 8'd0) ? 32'd1 : {24'd0, r_latched}) * 32'(OFF_SCALE);

    // Distance latch and beep on/off gating, active only in ALERT.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_latched  <= '0;
            r_beep_on  <= 1'b0;
            r_gate_cnt <= '0;
            r_off_len  <= '0;
        end else begin
            if (w_near) r_latched <= Distance;
            if (w_state_nxt != S_ALERT) begin
                r_beep_on  <= 1'b0;
                r_gate_cnt <= '0;
            end else if (w_enter_alert) begin
                r_beep_on  <= 1'b1;
                r_gate_cnt <= '0;
            end else if (r_beep_on) begin
                if (r_gate_cnt == 32'(BEEP_ON - 1)) begin
                    r_beep_on  <= 1'b0;
                    r_gate_cnt <= '0;
                    r_off_len  <= w_off_len;
                end else begin
                    r_gate_cnt <= r_gate_cnt + 32'd1;
                end
            end else begin
                if (r_gate_cnt == r_off_len - 32'd1) begin
                    r_beep_on  <= 1'b1;
                    r_gate_cnt <= '0;
                end else begin
                    r_gate_cnt <= r_gate_cnt + 32'd1;
                end
            end
        end
    end

    // Free-running square-wave tone.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
        end else if (r_tone_cnt == 32'(TONE_HALF - 1)) begin
            r_tone_cnt <= '0;
            r_tone     <= ~r_tone;
        end else begin
            r_tone_cnt <= r_tone_cnt + 32'd1;
        end
    end

    assign w_sample = (r_state == S_ALERT && r_beep_on) ?
                      (r_tone ? $signed(AMP) : -$signed(AMP)) : 16'sd0;

    // Frame serialiser: sample captured at frame start, shifted out MSB first.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_frame_cnt <= '0;
            r_shift     <= '0;
            r_sdata     <= 1'b0;
            r_strig     <= 1'b0;
        end else begin
            r_frame_cnt <= (r_frame_cnt == FW'(FRAME_LEN - 1)) ? '0 : r_frame_cnt + 1'b1;
            if (r_frame_cnt == '0) begin
                r_shift <= w_sample;
                r_strig <= 1'b1;
                r_sdata <= 1'b0;
            end else begin
                r_strig <= 1'b0;
                if (r_frame_cnt <= FW'(16)) begin
                    r_sdata <= r_shift[15];
                    r_shift <= r_shift <<< 1;
                end else begin
                    r_sdata <= 1'b0;
                end
            end
        end
    end

    assign Alarm      = r_alarm;
    assign State      = r_state;
    assign Sound_Data = r_sdata;
    assign Sound_Trig = r_strig;

endmodule

// File: tb/tb_proximity_alarm_sequencer.sv
// Directed testbench for proximity_alarm_sequencer (HOLD_CYC=100, BEEP_ON=10, OFF_SCALE=2).
module tb_proximity_alarm_sequencer;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] Distance = 8'd0;
    logic       Dist_Valid = 1'b0;
    logic       Enable = 1'b0;
    logic       Alarm;
    logic [1:0] State;
    logic       Sound_Data;
    logic       Sound_Trig;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    proximity_alarm_sequencer #(
        .HOLD_CYC (100),
        .BEEP_ON  (10),
        .OFF_SCALE(2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Distance  (Distance),
        .Dist_Valid(Dist_Valid),
        .Enable    (Enable),
        .Alarm     (Alarm),
        .State     (State),
        .Sound_Data(Sound_Data),
        .Sound_Trig(Sound_Trig)
    );

    always #5 CLK = ~CLK;

    // Clock edges since reset release; frame and tone phase derive from it.
    always @(posedge CLK or negedge RST)
        if (!RST) cyc <= 0;
        else      cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic strobe(input logic [7:0] d);
        Distance   = d;
        Dist_Valid = 1'b1;
        step();
        Dist_Valid = 1'b0;
    endtask

    task automatic align(input int m);
        for (int i = 0; i < 40 && (cyc % 32) != m; i++) step();
        checks++;
        if ((cyc % 32) != m) begin
            failures++;
            $display("FAIL align: frame phase %0d, wanted %0d", cyc % 32, m);
        end
    endtask

    task automatic read_word(output logic [15:0] w, output int c_latch, output logic trig);
        align(0);
        c_latch = cyc;
        step();
        trig = Sound_Trig && !Sound_Data;
        for (int b = 15; b >= 0; b--) begin
            step();
            w[b] = Sound_Data;
        end
    endtask

    // Expected frame word for a sample captured at edge count c, ALERT entered at c0.
    function automatic logic [15:0] exp_word(input int c, input int c0, input int off1, input int off2);
        int p;
        bit on;
        p = c - c0;
        if (p < 10)             on = 1'b1;
        else if (p < 10 + off1) on = 1'b0;
        else                    on = (((p - 10 - off1) % (10 + off2)) < 10);
        if (!on) return 16'h0000;
        return (((c / 25) % 2) == 1) ? 16'h3000 : 16'hD000;
    endfunction

    task automatic test_reset();
        int bad_st, bad_sd, bad_tr;
        #1;
        checks++;
        if ({State, Alarm, Sound_Data, Sound_Trig} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 00000", {State, Alarm, Sound_Data, Sound_Trig});
        end
        step(); step();
        checks++;
        if (Sound_Trig !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_trig: got %b expected 0", Sound_Trig);
        end
        RST = 1'b1;
        bad_st = 0; bad_sd = 0; bad_tr = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            checks += 3;
            if (State !== 2'b00 || Alarm !== 1'b0) bad_st++;
            if (Sound_Data !== 1'b0) bad_sd++;
            if (Sound_Trig !== ((cyc % 32) == 1)) begin
                bad_tr++;
                $display("FAIL idle_trig: edge %0d got %b expected %b", cyc, Sound_Trig, (cyc % 32) == 1);
            end
        end
        failures += bad_st + bad_sd + bad_tr;
        if (bad_st != 0) $display("FAIL idle_state: %0d bad cycles, expected State=00 Alarm=0", bad_st);
        if (bad_sd != 0) $display("FAIL idle_data: %0d cycles with Sound_Data=1, expected 0", bad_sd);
    endtask

    task automatic test_arm_alert();
        logic [15:0] w;
        logic        t;
        int          c, c0;
        Enable = 1'b1;
        step();
        checks++;
        if (State !== 2'b01) begin failures++; $display("FAIL arm: State got %b expected 01", State); end
        for (int i = 0; i < 3; i++) begin
            strobe(8'd50);
            checks++;
            if (State !== 2'b01) begin failures++; $display("FAIL pre_alert_%0d: State got %b expected 01", i, State); end
        end
        align(31);
        strobe(8'd50);
        c0 = cyc;
        checks++;
        if (State !== 2'b10 || Alarm !== 1'b1) begin
            failures++;
            $display("FAIL alert_entry: State/Alarm got %b/%b expected 10/1", State, Alarm);
        end
        read_word(w, c, t);
        checks += 2;
        if (t !== 1'b1) begin failures++; $display("FAIL alert_trig: got %b expected 1", t); end
        if (w !== exp_word(c, c0, 100, 100)) begin
            failures++;
            $display("FAIL alert_frame: got %h expected %h", w, exp_word(c, c0, 100, 100));
        end
        read_word(w, c, t);
        checks++;
        if (w !== 16'h0000) begin failures++; $display("FAIL alert_gap_frame: got %h expected 0000", w); end
    endtask

    task automatic test_confirm();
        logic [7:0] seq_a [6] = '{8'd50, 8'd50, 8'd150, 8'd50, 8'd50, 8'd50};
        logic [7:0] seq_b [7] = '{8'd50, 8'd50, 8'd50, 8'd0, 8'd50, 8'd50, 8'd50};
        Enable = 1'b0;
        step();
        checks++;
        if (State !== 2'b00 || Alarm !== 1'b0) begin
            failures++;
            $display("FAIL disable: State/Alarm got %b/%b expected 00/0", State, Alarm);
        end
        Enable = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            strobe(seq_a[i]);
            checks++;
            if (State !== 2'b01) begin failures++; $display("FAIL far_break_%0d: State got %b expected 01", i, State); end
        end
        strobe(8'd50);
        checks++;
        if (State !== 2'b10) begin failures++; $display("FAIL far_break_alert: State got %b expected 10", State); end
        Enable = 1'b0;
        step();
        Enable = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            strobe(seq_b[i]);
            checks++;
            if (State !== 2'b01) begin failures++; $display("FAIL zero_break_%0d: State got %b expected 01", i, State); end
        end
        strobe(8'd50);
        checks++;
        if (State !== 2'b10) begin failures++; $display("FAIL zero_break_alert: State got %b expected 10", State); end
    endtask

    task automatic test_hold();
        logic [15:0] w;
        logic        t;
        int          c, n;
        for (int i = 0; i < 3; i++) begin
            strobe(8'd200);
            checks++;
            if (State !== 2'b10) begin failures++; $display("FAIL pre_hold_%0d: State got %b expected 10", i, State); end
        end
        strobe(8'd200);
        checks++;
        if (State !== 2'b11 || Alarm !== 1'b0) begin
            failures++;
            $display("FAIL hold_entry: State/Alarm got %b/%b expected 11/0", State, Alarm);
        end
        read_word(w, c, t);
        checks++;
        if (w !== 16'h0000) begin failures++; $display("FAIL hold_frame: got %h expected 0000", w); end
        strobe(8'd30);
        checks++;
        if (State !== 2'b10 || Alarm !== 1'b1) begin
            failures++;
            $display("FAIL hold_near: State/Alarm got %b/%b expected 10/1", State, Alarm);
        end
        for (int i = 0; i < 4; i++) strobe(8'd200);
        n = 1;
        for (int i = 0; i < 300 && State == 2'b11; i++) begin
            step();
            if (State == 2'b11) n++;
        end
        checks += 2;
        if (n != 100) begin failures++; $display("FAIL hold_length: got %0d cycles expected 100", n); end
        if (State !== 2'b01) begin failures++; $display("FAIL hold_rearm: State got %b expected 01", State); end
    endtask

    // mode 0: entry 20; 1: entry 5; 2: 5 during on phase; 3: 5 during off phase
    task automatic beep_case(input int mode, input int off1, input int off2);
        logic [15:0] w, e;
        logic        t;
        int          c, c0;
        Enable = 1'b0;
        step();
        Enable = 1'b1;
        step();
        for (int i = 0; i < 4; i++) strobe((mode == 1) ? 8'd5 : 8'd20);
        c0 = cyc;
        checks++;
        if (State !== 2'b10) begin failures++; $display("FAIL beep%0d_entry: State got %b expected 10", mode, State); end
        if (mode == 2) begin
            step();
            strobe(8'd5);
        end else if (mode == 3) begin
            for (int i = 0; i < 15; i++) step();
            strobe(8'd5);
        end
        for (int f = 0; f < 6; f++) begin
            read_word(w, c, t);
            e = exp_word(c, c0, off1, off2);
            checks += 2;
            if (t !== 1'b1) begin failures++; $display("FAIL beep%0d_trig_%0d: got %b expected 1", mode, f, t); end
            if (w !== e) begin
                failures++;
                $display("FAIL beep%0d_frame_%0d: phase %0d got %h expected %h", mode, f, c - c0, w, e);
            end
        end
    endtask

    task automatic test_beep();
        beep_case(0, 40, 40);
        beep_case(1, 10, 10);
        beep_case(2, 10, 10);
        beep_case(3, 40, 10);
    endtask

    task automatic test_enable_drop();
        logic [15:0] w;
        logic        t;
        int          c, c0;
        Enable = 1'b0;
        step();
        Enable = 1'b1;
        step();
        for (int i = 0; i < 3; i++) strobe(8'd50);
        align(31);
        strobe(8'd50);
        c0 = cyc;
        step();
        checks++;
        if (Sound_Trig !== 1'b1) begin failures++; $display("FAIL drop_trig: got %b expected 1", Sound_Trig); end
        for (int b = 15; b >= 11; b--) begin
            step();
            w[b] = Sound_Data;
        end
        Enable = 1'b0;
        step();
        w[10] = Sound_Data;
        checks++;
        if (State !== 2'b00 || Alarm !== 1'b0) begin
            failures++;
            $display("FAIL drop_state: State/Alarm got %b/%b expected 00/0", State, Alarm);
        end
        for (int b = 9; b >= 0; b--) begin
            step();
            w[b] = Sound_Data;
        end
        checks++;
        if (w !== exp_word(c0, c0, 100, 100)) begin
            failures++;
            $display("FAIL drop_inflight: got %h expected %h", w, exp_word(c0, c0, 100, 100));
        end
        read_word(w, c, t);
        checks++;
        if (w !== 16'h0000) begin failures++; $display("FAIL drop_next_frame: got %h expected 0000", w); end

        Enable = 1'b1;
        step();
        for (int i = 0; i < 3; i++) strobe(8'd50);
        align(31);
        strobe(8'd50);
        align(5);
        checks++;
        if (Sound_Data !== 1'b1 || State !== 2'b10 || Alarm !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: Data/State/Alarm got %b/%b/%b expected 1/10/1", Sound_Data, State, Alarm);
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({State, Alarm, Sound_Data, Sound_Trig} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset: got %b expected 00000", {State, Alarm, Sound_Data, Sound_Trig});
        end
        Enable = 1'b0;
        step();
        step();
        RST = 1'b1;
        step();
        checks++;
        if (Sound_Trig !== 1'b1 || State !== 2'b00) begin
            failures++;
            $display("FAIL release_trig: Trig/State got %b/%b expected 1/00", Sound_Trig, State);
        end
    endtask

    initial begin
        test_reset();
        test_arm_alert();
        test_confirm();
        test_hold();
        test_beep();
        test_enable_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proximity_alarm_sequencer.md
Name: proximity_alarm_sequencer

Overview:
Downstream consumer of the ultrasonic sensor controller's 8-bit raw distance (cm). Qualifies near/far detections with consecutive-sample confirmation and runs an arm/alert/hold state machine. Generates a distance-modulated beep pattern, and serialises 16-bit signed audio samples to the DAC decoder as a framed bitstream (Sound_Data/Sound_Trig). Runs entirely on the divided trigger clock.

Parameters:
THRESH, 100, alarm when 0 < Distance < THRESH (cm)
CONFIRM_N, 4, consecutive qualifying samples needed to enter or leave alert
HOLD_CYC, 50000, cycles spent in HOLD before re-arming
TONE_HALF, 25, cycles per half period of the square-wave tone
BEEP_ON, 5000, cycles a beep is sounding
OFF_SCALE, 100, beep gap cycles per cm of latched distance
AMP, 16'h3000, tone amplitude (positive half; negative half = -AMP two's complement)
FRAME_LEN, 32, cycles per serial audio frame (must be >= 17)

Ports:
CLK  in  1  trigger clock (divided board clock)
RST  in  1  reset, asynchronous, active-low
Distance  in  8  raw distance in cm from sensor controller; 0 = no echo / timeout
Dist_Valid  in  1  one-cycle strobe: Distance holds a new measurement
Enable  in  1  system armed switch
Alarm  out  1  high while in ALERT
State  out  2  00 IDLE, 01 ARMED, 10 ALERT, 11 HOLD
Sound_Data  out  1  serial sample bit, MSB first
Sound_Trig  out  1  one-cycle frame-start pulse

Behaviour:
- Reset (RST=0, async): state IDLE; Alarm, Sound_Data, Sound_Trig = 0; all counters, shift register and latched distance = 0. All outputs registered.
- Sample classification, evaluated only on Dist_Valid:
  - near = (Distance != 0) and (Distance < THRESH)
  - far = Distance >= THRESH
  - Distance == 0 is neither; it clears both counters.
- Counters:
  - near_cnt increments on near and clears on far; saturates at CONFIRM_N.
  - far_cnt is symmetric.
- FSM:
  - IDLE: Enable=1 -> ARMED, counters cleared.
  - ARMED: near_cnt reaches CONFIRM_N -> ALERT. The transition is registered the cycle after the CONFIRM_N-th strobe.
  - ALERT: far_cnt reaches CONFIRM_N -> HOLD.
  - HOLD: any single near sample -> ALERT immediately. Otherwise, after HOLD_CYC cycles -> ARMED with counters cleared.
  - Enable=0 in any state -> IDLE next cycle. Enable has priority over all other transitions.
- Alarm = (State == ALERT).
- Beep gating (ALERT only):
  - Latch Distance on each near strobe, and on ALERT entry.
  - Beep on for BEEP_ON cycles, then off for max(latched,1)*OFF_SCALE cycles; repeat.
  - Gate counter restarts in the on phase at ALERT entry. A new latched distance takes effect at the next off phase.
- Tone: a free-running toggle every TONE_HALF cycles.
  - sample = +AMP when beep on and tone high; -AMP when beep on and tone low; 0 otherwise (including all non-ALERT states).
- Serialiser: a free-running frame counter 0..FRAME_LEN-1.
  - Cycle 0: Sound_Trig=1, current sample latched into the shift register, Sound_Data=0.
  - Cycles 1..16: Sound_Data = sample bits 15..0.
  - Cycles 17..FRAME_LEN-1: Sound_Data=0.
  - A sample change mid-frame never corrupts the frame in flight.
- Reset mid-frame aborts the frame immediately. The first Sound_Trig after release occurs on the first clock edge with RST=1.

Test Plan:
- Reset release, Enable=0, 100 cycles -> State=00, Alarm=0, Sound_Trig pulses every 32 cycles starting at first edge, Sound_Data always 0.
- Enable=1, then 4 strobes Distance=50 -> State 01 then 10 on the cycle after the 4th strobe, Alarm=1. Frames carry 16'h3000 / 16'hD000 MSB-first while beeping.
- Same setup, but strobes 50,50,150,50,50,50 -> no ALERT until the 4th consecutive near sample; Distance=0 interleaved also restarts the count.
- In ALERT, 4 strobes Distance=200 -> HOLD and samples 0. One strobe Distance=30 during HOLD -> ALERT next cycle. With overrides (HOLD_CYC=100), no near strobe -> ARMED after 100 cycles.
- Overrides BEEP_ON=10, OFF_SCALE=2: latched 20 -> 10 cycles on, 40 off. Latched 5 -> 10 on, 10 off. New near strobe during the on phase applies from the next off phase.
- Drop Enable during ALERT mid-frame -> IDLE next cycle and Alarm=0. The in-flight frame completes unchanged, and later frames are 0. Assert RST mid-frame -> all outputs 0 asynchronously.
